sha256_msg_bridge: RTL
======================

SHA256_MSG_BRIDGE -- requirements
Module: sha256_msg_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 2048, meaning the maximum core-run cycles before the timeout error is flagged.
REQ-002 SHALL have parameter CORE_RST_CYCLES, default 2, meaning the number of cycles core_reset is held high per start.
REQ-003 SHALL use a single clock and a synchronous, active-high reset.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have port wr_en, input, 1 bit: register write strobe, one write per high cycle.
REQ-007 SHALL have port wr_addr, input, 5 bits: word index of the register being written.
REQ-008 SHALL have port wr_data, input, 32 bits: write data.
REQ-009 SHALL have port rd_en, input, 1 bit: register read strobe.
REQ-010 SHALL have port rd_addr, input, 5 bits: word index of the register being read.
REQ-011 SHALL have port rd_data, output, 32 bits: registered read data.
REQ-012 SHALL have port rd_valid, output, 1 bit: rd_data is valid this cycle.
REQ-013 SHALL have port core_message, output, [0:511]: message block driven to the SHA core.
REQ-014 SHALL have port core_reset, output, 1 bit: SHA core reset.
REQ-015 SHALL have port core_ready, input, 1 bit: SHA core done flag.
REQ-016 SHALL have port core_hash, input, 256 bits: SHA core digest.
REQ-017 SHALL have port irq, output, 1 bit: level interrupt, high while status.done=1.

Function
REQ-018 Register map: indices 0-15 = message words (MSG0-MSG15); 16 = CTRL (write-only); 17 = STATUS (read-only); 24-31 = DIGEST0-DIGEST7 (read-only).
REQ-019 A write to MSGi SHALL update core_message[32*i +: 32]; MSG0 therefore occupies bits [0:31], with the first message byte in bits [0:7].
REQ-020 The FSM SHALL have four states: IDLE, CRST, RUN, DONE.
REQ-021 A CTRL write with bit0=1 in IDLE or DONE SHALL move the FSM to CRST and clear done and timeout.
REQ-022 CRST SHALL hold core_reset=1 for exactly CORE_RST_CYCLES cycles, then enter RUN with core_reset=0.
REQ-023 In RUN, the first cycle with core_ready=1 SHALL latch core_hash into the digest buffer and enter DONE on the next edge.
REQ-024 DIGESTk SHALL return core_hash[255-32k -: 32], so DIGEST0 holds the most significant word.
REQ-025 STATUS SHALL read as bit0 done, bit1 busy (CRST or RUN), bit2 timeout, bit3 wr_err, and 0 in bits 31:4.
REQ-026 A MSG write or a CTRL start while busy SHALL be ignored and SHALL set wr_err (sticky).
REQ-027 A CTRL write with bit1=1 SHALL clear wr_err; if bit0 and bit1 are both set, the start and the clear SHALL both take effect.
REQ-028 Reads SHALL have one-cycle latency: rd_valid=1 and rd_data are valid on the cycle after rd_en; reads of unmapped indices and of CTRL SHALL return 0.
REQ-029 A read and a write in the same cycle to the same register SHALL return the pre-write value.
REQ-030 The digest buffer SHALL change only on a RUN-to-DONE capture and SHALL be readable in every state.

Reset
REQ-031 On reset: FSM=IDLE, core_message=0, digest buffer=0, all STATUS bits=0, rd_data=0, rd_valid=0, irq=0, and core_reset=1 for the reset cycle and 0 afterwards.
REQ-032 Reset asserted during CRST or RUN SHALL abort the run with no digest capture.

Configuration
REQ-033 With SHA_BRIDGE_TIMEOUT_EN defined, a RUN cycle counter SHALL set timeout and move the FSM to DONE without capture when TIMEOUT_CYCLES cycles elapse in RUN without core_ready; irq SHALL also assert.
REQ-034 With SHA_BRIDGE_TIMEOUT_EN undefined, RUN SHALL wait indefinitely, no counter logic SHALL exist, and STATUS bit2 SHALL read 0.

Structure
REQ-035 Package sha_bridge_pkg SHALL hold the register index constants, STATUS bit positions, and the FSM state typedef.
REQ-036 No sub-module is required; the FSM, register file, and digest buffer SHALL reside in sha256_msg_bridge.

Verification
REQ-037 "abc" block (MSG0=0x61626380, MSG1-MSG14=0, MSG15=0x00000018), then CTRL=1 -> after core_ready, DIGEST0 reads 0xBA7816BF, DIGEST7 reads 0xF20015AD, STATUS reads 0x1, irq=1.
REQ-038 Write MSG3=0xDEADBEEF during RUN -> core_message[96:127] unchanged, STATUS bit3=1; then CTRL=0x2 -> bit3 reads 0.
REQ-039 Reset asserted during RUN -> FSM=IDLE, STATUS=0, DIGEST0 reads 0, core_reset=1 for one cycle.
REQ-040 With SHA_BRIDGE_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, and core_ready tied 0 -> 16 cycles after entering RUN, STATUS reads 0x5.
REQ-041 rd_en with rd_addr=20 -> rd_valid=1 and rd_data=0 on the next cycle.
REQ-042 CTRL=0x1 with core_ready held 1 -> core_reset stays high for exactly 2 cycles; capture occurs on the first RUN cycle.

Source files
------------

// File: rtl/sha256_msg_bridge_pkg.sv
// Shared register indices, STATUS bit positions and FSM states
// for the SHA-256 message bridge.
package sha_bridge_pkg;

  localparam logic [4:0] IDX_CTRL    = 5'd16;
  localparam logic [4:0] IDX_STATUS  = 5'd17;
  localparam logic [4:0] IDX_DIGEST0 = 5'd24;

  localparam int ST_DONE  = 0;
  localparam int ST_BUSY  = 1;
  localparam int ST_TMO   = 2;
  localparam int ST_WRERR = 3;

  localparam int CTRL_START = 0;
  localparam int CTRL_CLR   = 1;

  typedef enum logic [1:0] {
    IDLE,
    CRST,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/sha256_msg_bridge.sv
// Register bridge between a 32-bit bus and a SHA-256 core.
// Define SHA_BRIDGE_TIMEOUT_EN to bound the RUN state by TIMEOUT_CYCLES.
module sha256_msg_bridge
  import sha_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES  = 2048,
  parameter int CORE_RST_CYCLES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [4:0]   wr_addr,
  input  logic [31:0]  wr_data,
  input  logic         rd_en,
  input  logic [4:0]   rd_addr,
  output logic [31:0]  rd_data,
  output logic         rd_valid,
  output logic [0:511] core_message,
  output logic         core_reset,
  input  logic         core_ready,
  input  logic [255:0] core_hash,
  output logic         irq
);

  if (CORE_RST_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("sha256_msg_bridge: cycle parameters must be >= 1");
  end

  localparam int RW = $clog2(CORE_RST_CYCLES + 1);

  state_t        state, state_nx;
  logic [RW-1:0] rst_cnt;
  logic [31:0]   msg [16];
  logic [255:0]  digest;
  logic [31:0]   dig_w [8];
  logic          wr_err, tmo_flag, tmo_hit;
  logic          busy, done;
  logic          msg_wr, ctrl_wr, start, start_ok, capture;
  logic [31:0]   status, rd_mux;

  assign busy     = (state == CRST) || (state == RUN);
  assign done     = (state == DONE);
  assign msg_wr   = wr_en && !wr_addr[4];
  assign ctrl_wr  = wr_en && (wr_addr == IDX_CTRL);
  assign start    = ctrl_wr && wr_data[CTRL_START];
  assign start_ok = start && !busy;
  assign capture  = (state == RUN) && core_ready;

  // reset input also drives the core reset so the core is
  // held during the bridge's own reset cycle
  assign core_reset = reset || (state == CRST);
  assign irq        = done;

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      core_message[32*i +: 32] = msg[i];
    end
    for (int k = 0; k < 8; k++) begin
      dig_w[k] = digest[255-32*k -: 32];
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE: if (start_ok) state_nx = CRST;
      CRST: begin
        if (rst_cnt == RW'(CORE_RST_CYCLES - 1)) state_nx = RUN;
      end
      RUN: if (capture || tmo_hit) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rst_cnt  <= '0;
      digest   <= '0;
      wr_err   <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      for (int i = 0; i < 16; i++) msg[i] <= '0;
    end else begin
      state    <= state_nx;
      rst_cnt  <= (state == CRST) ? rst_cnt + 1'b1 : '0;
      rd_valid <= rd_en;
      rd_data  <= rd_en ? rd_mux : '0;
      if (capture) digest <= core_hash;
      if (msg_wr && !busy) msg[wr_addr[3:0]] <= wr_data;
      // a fresh violation outranks a clear in the same write
      if ((msg_wr || start) && busy) wr_err <= 1'b1;
      else if (ctrl_wr && wr_data[CTRL_CLR]) wr_err <= 1'b0;
    end
  end

`ifdef SHA_BRIDGE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] run_cnt;

  assign tmo_hit = (state == RUN) && !core_ready &&
                   (run_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      run_cnt  <= '0;
      tmo_flag <= 1'b0;
    end else begin
      run_cnt <= (state == RUN) ? run_cnt + 1'b1 : '0;
      if (start_ok) tmo_flag <= 1'b0;
      else if (tmo_hit) tmo_flag <= 1'b1;
    end
  end
`else
  assign tmo_hit  = 1'b0;
  assign tmo_flag = 1'b0;
`endif

  always_comb begin
    status           = '0;
    status[ST_DONE]  = done;
    status[ST_BUSY]  = busy;
    status[ST_TMO]   = tmo_flag;
    status[ST_WRERR] = wr_err;
  end

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      !rd_addr[4]:                rd_mux = msg[rd_addr[3:0]];
      rd_addr == IDX_STATUS:      rd_mux = status;
      rd_addr[4:3] == IDX_DIGEST0[4:3]: rd_mux = dig_w[rd_addr[2:0]];
      default:                    rd_mux = '0;
    endcase
  end

endmodule
